// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed multichannel FIR:
// FSM state encoding, saturation limits and index-width helpers.
package fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } fir_state_e;

    // Largest value representable in a signed w-bit word (w <= 63).
    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    // Smallest value representable in a signed w-bit word (w <= 63).
    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

    // Width of the tap index; NTAPS is a power of two and at least 2.
    function automatic int tap_idx_w(input int ntaps);
        return (ntaps <= 2) ? 1 : $clog2(ntaps);
    endfunction

    // Width of the channel index; a single channel still needs one bit.
    function automatic int ch_idx_w(input int nch);
        return (nch <= 2) ? 1 : $clog2(nch);
    endfunction

endpackage

// File: rtl/fir_quantize.sv
// Combinational quantiser: optional round-half-up, arithmetic right shift,
// then clamp or wrap into DATAW bits. ovf reports that the shifted value
// did not fit in DATAW bits, whichever way it was then reduced.
// ACCW must stay at or below 62 so the range test fits in 64 bits.
module fir_quantize
    import fir_pkg::*;
#(
    parameter int ACCW      = 40,
    parameter int DATAW     = 16,
    parameter int OUT_SHIFT = 14,
    parameter int ROUND     = 1,
    parameter int SATURATE  = 1
) (
    input  logic signed [ACCW-1:0]  sum,
    output logic        [DATAW-1:0] q,
    output logic                    ovf
);

    // One guard bit so adding the rounding constant can never wrap.
    localparam int     EW   = ACCW + 1;
    localparam longint QMAX = sat_max(DATAW);
    localparam longint QMIN = sat_min(DATAW);

    function automatic logic signed [EW-1:0] round_shift(input logic signed [ACCW-1:0] s);
        logic signed [EW-1:0] ext;
        logic signed [EW-1:0] bias;
        ext  = {s[ACCW-1], s};
        bias = '0;
        if (ROUND != 0) bias[OUT_SHIFT-1] = 1'b1;
        return (ext + bias) >>> OUT_SHIFT;
    endfunction

    function automatic logic [DATAW-1:0] clamp(input logic signed [EW-1:0] v,
                                               input logic hi, input logic lo);
        if (SATURATE == 0) return v[DATAW-1:0];
        if (hi)            return QMAX[DATAW-1:0];
        if (lo)            return QMIN[DATAW-1:0];
        return v[DATAW-1:0];
    endfunction

    logic signed [EW-1:0] shifted;
    logic signed [63:0]   wide;
    logic                 hi;
    logic                 lo;

    // Scale the accumulator and reduce it to the output width.
    always_comb begin
        shifted = round_shift(sum);
        wide    = {{(64-EW){shifted[EW-1]}}, shifted};
        hi      = (wide > QMAX);
        lo      = (wide < QMIN);
        q       = clamp(shifted, hi, lo);
        ovf     = hi | lo;
    end

endmodule

// File: rtl/fir_tdm_multich.sv
// Multichannel FIR sharing one multiply-accumulate across NCH channels,
// one tap per clock. Coefficients are shared, runtime-writable while idle.
// Frame flow: IDLE (accept) -> MAC (NCH*NTAPS cycles) -> OUT (hold until taken).
// Optional build macro FIR_SAT_FLAG_EN adds the sticky per-channel sat_flag port.
module fir_tdm_multich
    import fir_pkg::*;
#(
    parameter int DATAW     = 16,
    parameter int COEFW     = 16,
    parameter int NTAPS     = 16,
    parameter int NCH       = 2,
    parameter int ACCW      = 40,
    parameter int OUT_SHIFT = 14,
    parameter int ROUND     = 1,
    parameter int SATURATE  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear_state,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NCH*DATAW-1:0]          in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NCH*DATAW-1:0]          out_data,
    input  logic                          coef_we,
    input  logic [tap_idx_w(NTAPS)-1:0]   coef_addr,
    input  logic [COEFW-1:0]              coef_data,
`ifdef FIR_SAT_FLAG_EN
    output logic [NCH-1:0]                sat_flag,
`endif
    output logic                          busy
);

    localparam int TW  = tap_idx_w(NTAPS);
    localparam int CHW = ch_idx_w(NCH);
    localparam int PW  = DATAW + COEFW;

    fir_state_e              state_q, state_d;
    logic [TW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [TW-1:0]           k_q, k_d;
    logic [CHW-1:0]          ch_q, ch_d;
    logic signed [ACCW-1:0]  acc_q, acc_d;
    logic [NCH*DATAW-1:0]    out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [DATAW-1:0] dly_q  [0:NCH-1][0:NTAPS-1];
    logic signed [DATAW-1:0] dly_d  [0:NCH-1][0:NTAPS-1];
    logic signed [COEFW-1:0] coef_q [0:NTAPS-1];
    logic signed [COEFW-1:0] coef_d [0:NTAPS-1];
`ifdef FIR_SAT_FLAG_EN
    logic [NCH-1:0]          sat_q, sat_d;
    logic                    q_ovf;
`else
    logic                    unused_q_ovf;
`endif

    logic [TW-1:0]           rd_ptr;
    logic signed [DATAW-1:0] x_sel;
    logic signed [COEFW-1:0] c_sel;
    logic signed [PW-1:0]    prod;
    logic signed [ACCW-1:0]  prod_ext;
    logic signed [ACCW-1:0]  sum;
    logic [DATAW-1:0]        q;

    // Shared MAC datapath: select sample/coefficient for tap k of channel ch.
    always_comb begin
        rd_ptr   = wr_ptr_q - k_q;
        x_sel    = dly_q[ch_q][rd_ptr];
        c_sel    = coef_q[k_q];
        prod     = x_sel * c_sel;
        prod_ext = {{(ACCW-PW){prod[PW-1]}}, prod};
        sum      = acc_q + prod_ext;
    end

    fir_quantize #(
        .ACCW      (ACCW),
        .DATAW     (DATAW),
        .OUT_SHIFT (OUT_SHIFT),
        .ROUND     (ROUND),
        .SATURATE  (SATURATE)
    ) u_quant (
        .sum (sum),
        .q   (q),
`ifdef FIR_SAT_FLAG_EN
        .ovf (q_ovf)
`else
        .ovf (unused_q_ovf)
`endif
    );

    // Next-state logic for the frame FSM, delay lines and coefficient bank.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        k_d         = k_q;
        ch_d        = ch_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        dly_d       = dly_q;
        coef_d      = coef_q;
`ifdef FIR_SAT_FLAG_EN
        sat_d       = sat_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // The write lands on the same edge as a handshake, so the
                // accepted frame already sees the new coefficient.
                if (coef_we) coef_d[coef_addr] = coef_data;
                if (in_valid) begin
                    for (int c = 0; c < NCH; c++)
                        dly_d[c][wr_ptr_q] = in_data[c*DATAW +: DATAW];
                    acc_d   = '0;
                    k_d     = '0;
                    ch_d    = '0;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                if (k_q == TW'(NTAPS-1)) begin
                    out_data_d[ch_q*DATAW +: DATAW] = q;
`ifdef FIR_SAT_FLAG_EN
                    if (q_ovf) sat_d[ch_q] = 1'b1;
`endif
                    acc_d = '0;
                    k_d   = '0;
                    if (ch_q == CHW'(NCH-1)) begin
                        ch_d        = '0;
                        out_valid_d = 1'b1;
                        state_d     = ST_OUT;
                    end else begin
                        ch_d = ch_q + 1'b1;
                    end
                end else begin
                    acc_d = sum;
                    k_d   = k_q + 1'b1;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    wr_ptr_d    = wr_ptr_q + 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Flush wins over any input or coefficient write on the same edge;
        // the coefficient bank itself survives.
        if (clear_state) begin
            state_d     = ST_IDLE;
            wr_ptr_d    = '0;
            k_d         = '0;
            ch_d        = '0;
            acc_d       = '0;
            out_data_d  = '0;
            out_valid_d = 1'b0;
            coef_d      = coef_q;
            for (int c = 0; c < NCH; c++)
                for (int t = 0; t < NTAPS; t++)
                    dly_d[c][t] = '0;
`ifdef FIR_SAT_FLAG_EN
            sat_d       = '0;
`endif
        end
    end

    // State registers; rst clears everything including the coefficients.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            k_q         <= '0;
            ch_q        <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            for (int c = 0; c < NCH; c++)
                for (int t = 0; t < NTAPS; t++)
                    dly_q[c][t] <= '0;
            for (int t = 0; t < NTAPS; t++)
                coef_q[t] <= '0;
`ifdef FIR_SAT_FLAG_EN
            sat_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            k_q         <= k_d;
            ch_q        <= ch_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            dly_q       <= dly_d;
            coef_q      <= coef_d;
`ifdef FIR_SAT_FLAG_EN
            sat_q       <= sat_d;
`endif
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
`ifdef FIR_SAT_FLAG_EN
    assign sat_flag  = sat_q;
`endif

endmodule

// File: tb/tb_fir_tdm_multich.sv
// Directed bench for fir_tdm_multich (NCH=2, NTAPS=16, OUT_SHIFT=14, ROUND=1).
// A saturating instance and a wrapping twin share the same stimulus.
`timescale 1ns/1ps
module tb_fir_tdm_multich;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clear_state, in_valid, out_ready, coef_we;
    logic [31:0] in_data;
    logic [3:0]  coef_addr;
    logic [15:0] coef_data;
    logic        in_ready, out_valid, busy;
    logic [31:0] out_data;
    logic        in_ready_w, out_valid_w, busy_w;
    logic [31:0] out_data_w;
`ifdef FIR_SAT_FLAG_EN
    logic [1:0]  sat_flag, sat_flag_w;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int acc_cyc;
    int lat;
    logic signed [15:0] r0, r1, rw0;

    always @(posedge clk) cyc <= cyc + 1;

    fir_tdm_multich #(.SATURATE(1)) dut (
        .clk(clk), .rst(rst), .clear_state(clear_state),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
`ifdef FIR_SAT_FLAG_EN
        .sat_flag(sat_flag),
`endif
        .busy(busy)
    );

    fir_tdm_multich #(.SATURATE(0)) dut_w (
        .clk(clk), .rst(rst), .clear_state(clear_state),
        .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
`ifdef FIR_SAT_FLAG_EN
        .sat_flag(sat_flag_w),
`endif
        .busy(busy_w)
    );

    task automatic do_reset();
        rst = 1'b1; clear_state = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0; in_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk); clear_state = 1'b1;
        @(posedge clk); #1 clear_state = 1'b0;
    endtask

    task automatic write_coef(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk); coef_we = 1'b1; coef_addr = a; coef_data = d;
        @(posedge clk); #1 coef_we = 1'b0;
    endtask

    task automatic accept(input logic signed [15:0] d0, input logic signed [15:0] d1);
        bit done = 1'b0;
        @(negedge clk); in_valid = 1'b1; in_data = {d1, d0};
        for (int i = 0; i < 200 && !done; i++) begin
            if (in_ready) begin
                @(posedge clk); acc_cyc = cyc; done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        #1 in_valid = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready low for 200 cycles, required high");
        end
    endtask

    task automatic get_out(input bit consume);
        bit got = 1'b0;
        lat = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk); lat++;
            if (out_valid) begin
                got = 1'b1;
                r0 = out_data[15:0]; r1 = out_data[31:16]; rw0 = out_data_w[15:0];
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL out_timeout: out_valid low for 200 cycles, required high");
        end else if (consume) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input logic signed [15:0] d0, input logic signed [15:0] d1);
        out_ready = 1'b1;
        accept(d0, d1);
        get_out(1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h required 0", out_data); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        // Coefficient bank is zero after reset, so any frame filters to zero.
        send_frame(16'sd1000, -16'sd1000);
        checks++; if (r0 !== 16'sd0) begin errors++; $display("FAIL reset_coef_ch0: got %0d required 0", r0); end
        checks++; if (r1 !== 16'sd0) begin errors++; $display("FAIL reset_coef_ch1: got %0d required 0", r1); end
    endtask

    task automatic test_impulse();
        int e;
        do_clear();
        for (int k = 0; k < 16; k++) write_coef(4'(k), 16'(100 * (k + 1)));
        for (int n = 0; n < 17; n++) begin
            send_frame((n == 0) ? 16'sd16384 : 16'sd0, 16'sd0);
            e = (n < 16) ? 100 * (n + 1) : 0;
            if (n == 0) begin
                checks++;
                if (lat !== 33) begin errors++; $display("FAIL latency: got %0d required 33", lat); end
            end
            checks++; if (r0 !== 16'(e)) begin errors++; $display("FAIL impulse_ch0 frame %0d: got %0d required %0d", n, r0, e); end
            checks++; if (r1 !== 16'sd0) begin errors++; $display("FAIL impulse_ch1 frame %0d: got %0d required 0", n, r1); end
        end
    endtask

    task automatic test_back_to_back();
        int c1;
        do_clear();
        send_frame(16'sd0, 16'sd0);
        c1 = acc_cyc;
        send_frame(16'sd0, 16'sd0);
        checks++;
        if (acc_cyc - c1 !== 34) begin errors++; $display("FAIL throughput: got %0d cycles required 34", acc_cyc - c1); end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        logic [31:0] held;
        do_clear();
        out_ready = 1'b0;
        accept(16'sd16384, 16'sd0);
        get_out(1'b0);
        held = out_data;
        checks++; if (r0 !== 16'sd100) begin errors++; $display("FAIL bp_first: got %0d required 100", r0); end
        in_valid = 1'b1; in_data = '0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0 || busy !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles required 0", bad); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        accept(16'sd0, 16'sd0);
        get_out(1'b1);
        checks++; if (r0 !== 16'sd200) begin errors++; $display("FAIL bp_second: got %0d required 200", r0); end
        send_frame(16'sd0, 16'sd0);
        checks++; if (r0 !== 16'sd300) begin errors++; $display("FAIL bp_third: got %0d required 300", r0); end
    endtask

    task automatic test_clear_state();
        int seen = 0;
        do_clear();
        accept(16'sd5000, 16'sd5000);
        repeat (9) @(negedge clk);
        clear_state = 1'b1;
        @(posedge clk); #1 clear_state = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_busy: got %b required 0", busy); end
        for (int i = 0; i < 60; i++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL clear_no_output: got %0d valid cycles required 0", seen); end
        for (int n = 0; n < 4; n++) begin
            send_frame((n == 0) ? 16'sd16384 : 16'sd0, 16'sd0);
            checks++; if (r0 !== 16'(100 * (n + 1))) begin errors++; $display("FAIL clear_impulse frame %0d: got %0d required %0d", n, r0, 100 * (n + 1)); end
        end
    endtask

    task automatic test_coef_write();
        do_clear();
        fork
            send_frame(16'sd16384, 16'sd0);
            begin
                repeat (5) @(negedge clk);
                coef_we = 1'b1; coef_addr = 4'd0; coef_data = 16'd5000;
                @(posedge clk); #1 coef_we = 1'b0;
            end
        join
        checks++; if (r0 !== 16'sd100) begin errors++; $display("FAIL coef_busy_drop: got %0d required 100", r0); end
        do_clear();
        coef_we = 1'b1; coef_addr = 4'd0; coef_data = 16'd5000;
        out_ready = 1'b1;
        accept(16'sd16384, 16'sd0);
        coef_we = 1'b0;
        get_out(1'b1);
        checks++; if (r0 !== 16'sd5000) begin errors++; $display("FAIL coef_idle_write: got %0d required 5000", r0); end
    endtask

    task automatic test_hpf_dc();
        int hpf [16] = '{-1000, -2000, -4000, 14000, -4000, -2000, -1000, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        do_clear();
        for (int k = 0; k < 16; k++) write_coef(4'(k), 16'(hpf[k]));
        for (int n = 0; n < 17; n++) begin
            send_frame(16'sd8000, 16'sd8000);
            if (n == 3) begin
                checks++; if (r0 !== 16'sd3418) begin errors++; $display("FAIL hpf_dc_partial: got %0d required 3418", r0); end
            end
            if (n >= 15) begin
                checks++; if (r0 !== 16'sd0) begin errors++; $display("FAIL hpf_dc_ch0 frame %0d: got %0d required 0", n, r0); end
                checks++; if (r1 !== 16'sd0) begin errors++; $display("FAIL hpf_dc_ch1 frame %0d: got %0d required 0", n, r1); end
            end
        end
    endtask

    task automatic test_hpf_alt();
        logic signed [15:0] d;
        do_clear();
        for (int n = 0; n < 16; n++) begin
            d = (n % 2 == 0) ? 16'sd8000 : -16'sd8000;
            send_frame(d, -d);
            if (n == 14) begin
                checks++; if (r0 !== -16'sd9766) begin errors++; $display("FAIL hpf_alt_ch0_even: got %0d required -9766", r0); end
                checks++; if (r1 !== 16'sd9766)  begin errors++; $display("FAIL hpf_alt_ch1_even: got %0d required 9766", r1); end
            end
            if (n == 15) begin
                checks++; if (r0 !== 16'sd9766)  begin errors++; $display("FAIL hpf_alt_ch0_odd: got %0d required 9766", r0); end
                checks++; if (r1 !== -16'sd9766) begin errors++; $display("FAIL hpf_alt_ch1_odd: got %0d required -9766", r1); end
            end
        end
    endtask

    task automatic test_saturation();
        do_clear();
        for (int k = 0; k < 16; k++) write_coef(4'(k), 16'd16384);
        send_frame(16'sd30000, 16'sd30000);
        checks++; if (r0 !== 16'sd30000)  begin errors++; $display("FAIL sat_f0: got %0d required 30000", r0); end
        checks++; if (rw0 !== 16'sd30000) begin errors++; $display("FAIL wrap_f0: got %0d required 30000", rw0); end
`ifdef FIR_SAT_FLAG_EN
        checks++; if (sat_flag !== 2'b00) begin errors++; $display("FAIL sat_flag_f0: got %b required 00", sat_flag); end
`endif
        send_frame(16'sd30000, 16'sd30000);
        checks++; if (r0 !== 16'sd32767)  begin errors++; $display("FAIL sat_f1: got %0d required 32767", r0); end
        checks++; if (rw0 !== 16'hEA60)   begin errors++; $display("FAIL wrap_f1: got %h required ea60", rw0); end
        for (int n = 2; n < 16; n++) send_frame(16'sd30000, 16'sd30000);
        checks++; if (r0 !== 16'sd32767)  begin errors++; $display("FAIL sat_full_ch0: got %0d required 32767", r0); end
        checks++; if (r1 !== 16'sd32767)  begin errors++; $display("FAIL sat_full_ch1: got %0d required 32767", r1); end
        checks++; if (rw0 !== 16'h5300)   begin errors++; $display("FAIL wrap_full: got %h required 5300", rw0); end
`ifdef FIR_SAT_FLAG_EN
        checks++; if (sat_flag !== 2'b11)   begin errors++; $display("FAIL sat_flag_set: got %b required 11", sat_flag); end
        checks++; if (sat_flag_w !== 2'b11) begin errors++; $display("FAIL wrap_flag_set: got %b required 11", sat_flag_w); end
`endif
        do_clear();
`ifdef FIR_SAT_FLAG_EN
        checks++; if (sat_flag !== 2'b00) begin errors++; $display("FAIL sat_flag_clear: got %b required 00", sat_flag); end
`endif
        send_frame(-16'sd30000, -16'sd30000);
        checks++; if (r0 !== -16'sd30000) begin errors++; $display("FAIL sat_neg_f0: got %0d required -30000", r0); end
        send_frame(-16'sd30000, -16'sd30000);
        checks++; if (r0 !== -16'sd32768) begin errors++; $display("FAIL sat_neg_f1: got %0d required -32768", r0); end
        checks++; if (rw0 !== 16'h15A0)   begin errors++; $display("FAIL wrap_neg_f1: got %h required 15a0", rw0); end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_back_to_back();
        test_backpressure();
        test_clear_state();
        test_coef_write();
        test_hpf_dc();
        test_hpf_alt();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
